fetch_decode_unit: RTL and testbench
====================================

Name: fetch_decode_unit

Overview:
- Upstream stage of the register-file/ALU datapath: owns the PC, fetches 32-bit instructions over a req/ready memory handshake and decodes them.
- Drives the datapath's ad1/ad2/ad3, we3, imm_op, alusrc and aluctrl inputs.
- Consumes the datapath's eq flag to resolve BNE.
- Multi-cycle, one instruction in flight; supported subset: ADDI, ADD, BNE.

Parameters:
D_WIDTH, 32, datapath width; width of imm_op
A_WIDTH, 5, register address width
PC_WIDTH, 32, program counter / instruction address width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request; held until accepted
imem_addr  out  PC_WIDTH  fetch address (= pc)
imem_ready  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  instruction word
stall  in  1  hold current instruction in EXEC
eq  in  1  ALU equality flag (aluop1 == aluop2), combinational from datapath
ad1  out  A_WIDTH  rs1 field
ad2  out  A_WIDTH  rs2 field
ad3  out  A_WIDTH  rd field
we3  out  1  register write enable
alusrc  out  1  1 = ALU operand 2 is imm_op
aluctrl  out  4  0000 = ADD, 0001 = SUB
imm_op  out  D_WIDTH  sign-extended immediate
pc  out  PC_WIDTH  current PC
illegal  out  1  sticky unsupported-instruction / misaligned-target flag

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, pc = RESET_PC, IR = 0x00000013 (NOP), illegal = 0.
  - Outputs: imem_req = 0, we3 = 0, alusrc = 1, aluctrl = 0000, imm_op = 0, ad1 = ad2 = ad3 = 0.
  - Deassertion mid-fetch abandons the fetch; any late imem_ready is ignored until the next request.
- FSM:
  - IDLE: always advances to FETCH next cycle.
  - FETCH: imem_req = 1, imem_addr = pc, held stable. On imem_ready = 1, IR <= imem_rdata and go to EXEC; otherwise stay. Minimum latency is 1 FETCH cycle.
  - EXEC: decode outputs are valid from IR. If stall = 1: stay in EXEC, we3 forced 0, pc held. If stall = 0: we3 per decode for exactly this cycle, pc <= next_pc, go to FETCH.
- imem_ready is ignored outside FETCH. Throughput is 1 instruction per 2 cycles with zero-wait memory.
- Decode outputs are driven from IR in all states. we3 = 0 outside EXEC.
- Decode:
  - ADDI (opcode 0010011, funct3 000): we3 = 1, alusrc = 1, aluctrl = 0000, imm_op = sext(IR[31:20]).
  - ADD (opcode 0110011, funct3 000, funct7 0000000): we3 = 1, alusrc = 0, aluctrl = 0000.
  - BNE (opcode 1100011, funct3 001): we3 = 0, alusrc = 0, aluctrl = 0001, imm_op = sext({IR[31], IR[7], IR[30:25], IR[11:8], 0}).
  - Anything else: NOP (we3 = 0), illegal <= 1 when leaving EXEC.
- ad1 = IR[19:15], ad2 = IR[24:20], ad3 = IR[11:7] regardless of type. rd = x0 is still written; the register file ignores it.
- next_pc:
  - BNE with eq = 0 (taken): pc + sext(Bimm), truncated to PC_WIDTH.
  - Otherwise: pc + 4, modulo 2^PC_WIDTH (wraps from all-ones-minus-3 to 0).
  - Taken target with bit 1 set: branch not taken, pc + 4 used, illegal <= 1.
- eq is sampled on the EXEC edge that leaves EXEC; it may change freely during a stall.
- illegal stays 1 until reset.
- Sign extension: immediate sign bit replicated to D_WIDTH; truncated if D_WIDTH < 13 (not a supported configuration).

Test Plan:
- Reset: rst_n low mid-FETCH with imem_req = 1 -> same cycle imem_req = 0, pc = 0. After release: IDLE, FETCH at addr 0.
- ADDI x1, x0, -5 (0xFFB00093), zero-wait memory -> EXEC cycle: ad3 = 1, ad1 = 0, alusrc = 1, imm_op = 0xFFFFFFFB, we3 = 1 for one cycle; pc 0 -> 4.
- ADD x3, x1, x2 with imem_ready delayed 3 cycles -> imem_req high and imem_addr = 4 stable for 4 cycles; then we3 = 1, alusrc = 0, ad1 = 1, ad2 = 2, ad3 = 3.
- BNE x1, x0, -8 at pc = 8: eq = 0 -> pc = 0; eq = 1 -> pc = 12; we3 = 0 and aluctrl = 0001 in both cases.
- stall = 1 for 3 EXEC cycles on ADDI -> we3 = 0 throughout stall, pc unchanged; one we3 pulse after stall drops.
- Opcode 0x0000007F -> no write, pc += 4, illegal = 1 and stays 1. pc = 0xFFFFFFFC with NOP -> wraps to 0.

Source files
------------

// File: rtl/fetch_decode_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_unit
// Description : PC owner, req/ready instruction fetch and ADDI/ADD/BNE decode
//               feeding the register-file/ALU datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_unit #(
    parameter int                   D_WIDTH  = 32,
    parameter int                   A_WIDTH  = 5,
    parameter int                   PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    input  logic                stall,
    input  logic                eq,
    output logic [A_WIDTH-1:0]  ad1,
    output logic [A_WIDTH-1:0]  ad2,
    output logic [A_WIDTH-1:0]  ad3,
    output logic                we3,
    output logic                alusrc,
    output logic [3:0]          aluctrl,
    output logic [D_WIDTH-1:0]  imm_op,
    output logic [PC_WIDTH-1:0] pc,
    output logic                illegal
);

    localparam logic [31:0] c_NOP       = 32'h0000_0013;
    localparam logic [6:0]  c_OP_IMM    = 7'b0010011;
    localparam logic [6:0]  c_OP_REG    = 7'b0110011;
    localparam logic [6:0]  c_OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [31:0]         r_ir;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_illegal;

    logic                w_is_addi;
    logic                w_is_add;
    logic                w_is_bne;
    logic                w_we_dec;
    logic                w_leave_exec;
    logic [11:0]         w_i_imm;
    logic [12:0]         w_b_imm;
    logic [PC_WIDTH-1:0] w_pc_plus4;
    logic [PC_WIDTH-1:0] w_br_target;
    logic                w_taken;
    logic                w_misaligned;
    logic [PC_WIDTH-1:0] w_next_pc;

    assign w_is_addi = (r_ir[6:0] == c_OP_IMM) && (r_ir[14:12] == 3'b000);
    assign w_is_add  = (r_ir[6:0] == c_OP_REG) && (r_ir[14:12] == 3'b000)
                       && (r_ir[31:25] == 7'b0000000);
    assign w_is_bne  = (r_ir[6:0] == c_OP_BRANCH) && (r_ir[14:12] == 3'b001);

    assign w_i_imm = r_ir[31:20];
    assign w_b_imm = {r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};

    assign ad1 = A_WIDTH'(r_ir[19:15]);
    assign ad2 = A_WIDTH'(r_ir[24:20]);
    assign ad3 = A_WIDTH'(r_ir[11:7]);

    always_comb begin
        w_we_dec = 1'b0;
        alusrc   = 1'b1;
        aluctrl  = 4'b0000;
        imm_op   = '0;
        if (w_is_addi) begin
            w_we_dec = 1'b1;
            imm_op   = {{(D_WIDTH-12){w_i_imm[11]}}, w_i_imm};
        end else if (w_is_add) begin
            w_we_dec = 1'b1;
            alusrc   = 1'b0;
        end else if (w_is_bne) begin
            alusrc   = 1'b0;
            aluctrl  = 4'b0001;
            imm_op   = {{(D_WIDTH-13){w_b_imm[12]}}, w_b_imm};
        end
    end

    // A taken branch to a non-word-aligned target falls through and flags illegal.
    assign w_pc_plus4   = r_pc + PC_WIDTH'(4);
    assign w_br_target  = r_pc + {{(PC_WIDTH-13){w_b_imm[12]}}, w_b_imm};
    assign w_taken      = w_is_bne && !eq;
    assign w_misaligned = w_taken && w_br_target[1];
    assign w_next_pc    = (w_taken && !w_misaligned) ? w_br_target : w_pc_plus4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        we3          = 1'b0;
        w_leave_exec = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    we3          = w_we_dec;
                    w_leave_exec = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_ir      <= c_NOP;
            r_illegal <= 1'b0;
        end else begin
            if ((r_state == S_FETCH) && imem_ready) begin
                r_ir <= imem_rdata;
            end
            if (w_leave_exec) begin
                r_pc <= w_next_pc;
                if (!(w_is_addi || w_is_add || w_is_bne) || w_misaligned) begin
                    r_illegal <= 1'b1;
                end
            end
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_decode_unit
// Description : Scoreboard bench for fetch_decode_unit with a req/ready memory.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_decode_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        eq;
    logic [4:0]  ad1, ad2, ad3;
    logic        we3;
    logic        alusrc;
    logic [3:0]  aluctrl;
    logic [31:0] imm_op;
    logic [31:0] pc;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  ad1, ad2, ad3;
        logic        we3;
        logic        alusrc;
        logic [3:0]  aluctrl;
        logic [31:0] imm;
        bit          chk_alu;
        bit          chk_imm;
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    fetch_decode_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .eq         (eq),
        .ad1        (ad1),
        .ad2        (ad2),
        .ad3        (ad3),
        .we3        (we3),
        .alusrc     (alusrc),
        .aluctrl    (aluctrl),
        .imm_op     (imm_op),
        .pc         (pc),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                                input logic w, input logic src, input logic [3:0] ctl,
                                input logic [31:0] imm, input bit c_alu, input bit c_imm,
                                input logic [31:0] p, input logic [31:0] np, input logic il);
        exp_t e;
        e.ad1 = a1; e.ad2 = a2; e.ad3 = a3; e.we3 = w; e.alusrc = src; e.aluctrl = ctl;
        e.imm = imm; e.chk_alu = c_alu; e.chk_imm = c_imm; e.pc = p; e.next_pc = np; e.ill = il;
        return e;
    endfunction

    // Caller is positioned at a negedge; returns at a negedge with imem_req high.
    task automatic wait_req(input logic [31:0] exp_pc);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL req_timeout: imem_req=%b required 1", imem_req);
        end
        n_checks++;
        if (imem_addr !== exp_pc) begin
            n_fail++;
            $display("FAIL fetch_addr: imem_addr=%h required %h", imem_addr, exp_pc);
        end
    endtask

    task automatic run_instr(input logic [31:0] instr, input int delay, input int nstall,
                             input logic eqv, input exp_t e_in);
        exp_t e;
        wait_req(e_in.pc);
        for (int i = 0; i < delay; i++) begin
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== e_in.pc) begin
                n_fail++;
                $display("FAIL fetch_hold: req=%b addr=%h required req=1 addr=%h",
                         imem_req, imem_addr, e_in.pc);
            end
            @(negedge clk);
        end
        imem_ready = 1'b1;
        imem_rdata = instr;
        stall      = (nstall > 0);
        eq         = ~eqv;
        sb.push_back(e_in);
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        for (int s = 0; s < nstall; s++) begin
            #1;
            n_checks++;
            if (we3 !== 1'b0 || pc !== e_in.pc || imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold: we3=%b pc=%h req=%b required we3=0 pc=%h req=0",
                         we3, pc, imem_req, e_in.pc);
            end
            eq = ~eq;
            @(negedge clk);
        end
        stall = 1'b0;
        eq    = eqv;
        #1;
        e = sb.pop_front();
        n_checks++;
        if (ad1 !== e.ad1 || ad2 !== e.ad2 || ad3 !== e.ad3) begin
            n_fail++;
            $display("FAIL decode_regs: ad1=%0d ad2=%0d ad3=%0d required %0d %0d %0d",
                     ad1, ad2, ad3, e.ad1, e.ad2, e.ad3);
        end
        n_checks++;
        if (we3 !== e.we3) begin
            n_fail++;
            $display("FAIL exec_we3: we3=%b required %b", we3, e.we3);
        end
        if (e.chk_alu) begin
            n_checks++;
            if (alusrc !== e.alusrc || aluctrl !== e.aluctrl) begin
                n_fail++;
                $display("FAIL decode_alu: alusrc=%b aluctrl=%b required %b %b",
                         alusrc, aluctrl, e.alusrc, e.aluctrl);
            end
        end
        if (e.chk_imm) begin
            n_checks++;
            if (imm_op !== e.imm) begin
                n_fail++;
                $display("FAIL decode_imm: imm_op=%h required %h", imm_op, e.imm);
            end
        end
        n_checks++;
        if (pc !== e.pc) begin
            n_fail++;
            $display("FAIL exec_pc: pc=%h required %h", pc, e.pc);
        end
        @(negedge clk);
        n_checks++;
        if (pc !== e.next_pc || we3 !== 1'b0 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL after_exec: pc=%h we3=%b req=%b required pc=%h we3=0 req=1",
                     pc, we3, imem_req, e.next_pc);
        end
        n_checks++;
        if (illegal !== e.ill) begin
            n_fail++;
            $display("FAIL illegal_flag: illegal=%b required %b", illegal, e.ill);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        stall      = 1'b0;
        eq         = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || illegal !== 1'b0 || we3 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: req=%b pc=%h illegal=%b we3=%b required 0 0 0 0",
                     imem_req, pc, illegal, we3);
        end
        n_checks++;
        if (alusrc !== 1'b1 || aluctrl !== 4'b0000 || imm_op !== 32'h0 ||
            ad1 !== 5'd0 || ad2 !== 5'd0 || ad3 !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_decode: alusrc=%b aluctrl=%b imm=%h ad=%0d/%0d/%0d required 1 0000 0 0/0/0",
                     alusrc, aluctrl, imm_op, ad1, ad2, ad3);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: imem_req=%b required 0", imem_req);
        end
        @(negedge clk);
    endtask

    task automatic test_addi();
        run_instr(32'hFFB0_0093, 0, 0, 1'b0,
                  mk(5'd0, 5'd27, 5'd1, 1'b1, 1'b1, 4'b0000, 32'hFFFF_FFFB, 1, 1, 32'h0, 32'h4, 1'b0));
    endtask

    task automatic test_add_wait();
        run_instr(32'h0020_81B3, 3, 0, 1'b0,
                  mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 4'b0000, 32'h0, 1, 0, 32'h4, 32'h8, 1'b0));
    endtask

    task automatic test_bne_taken();
        run_instr(32'hFE00_9CE3, 0, 0, 1'b0,
                  mk(5'd1, 5'd0, 5'd25, 1'b0, 1'b0, 4'b0001, 32'hFFFF_FFF8, 1, 1, 32'h8, 32'h0, 1'b0));
    endtask

    task automatic test_stall();
        run_instr(32'hFFB0_0093, 0, 3, 1'b0,
                  mk(5'd0, 5'd27, 5'd1, 1'b1, 1'b1, 4'b0000, 32'hFFFF_FFFB, 1, 1, 32'h0, 32'h4, 1'b0));
    endtask

    task automatic test_back_to_back();
        run_instr(32'h0020_81B3, 0, 0, 1'b1,
                  mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 4'b0000, 32'h0, 1, 0, 32'h4, 32'h8, 1'b0));
        run_instr(32'hFE00_9CE3, 0, 0, 1'b1,
                  mk(5'd1, 5'd0, 5'd25, 1'b0, 1'b0, 4'b0001, 32'hFFFF_FFF8, 1, 1, 32'h8, 32'hC, 1'b0));
    endtask

    task automatic test_wrap();
        run_instr(32'hFE00_18E3, 0, 0, 1'b0,
                  mk(5'd0, 5'd0, 5'd17, 1'b0, 1'b0, 4'b0001, 32'hFFFF_FFF0, 1, 1, 32'hC, 32'hFFFF_FFFC, 1'b0));
        run_instr(32'h0000_0013, 1, 0, 1'b0,
                  mk(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 4'b0000, 32'h0, 1, 1, 32'hFFFF_FFFC, 32'h0, 1'b0));
    endtask

    task automatic test_illegal();
        run_instr(32'h0000_007F, 0, 0, 1'b0,
                  mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b0000, 32'h0, 0, 0, 32'h0, 32'h4, 1'b1));
        run_instr(32'hFFB0_0093, 0, 0, 1'b0,
                  mk(5'd0, 5'd27, 5'd1, 1'b1, 1'b1, 4'b0000, 32'hFFFF_FFFB, 1, 1, 32'h4, 32'h8, 1'b1));
    endtask

    task automatic test_reset_midfetch();
        wait_req(32'h8);
        imem_ready = 1'b1;
        imem_rdata = 32'hFFB0_0093;
        rst_n      = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL midfetch_reset: req=%b pc=%h illegal=%b required 0 0 0",
                     imem_req, pc, illegal);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL release_idle: imem_req=%b required 0", imem_req);
        end
        @(negedge clk);
        imem_ready = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL late_ready_ignored: req=%b addr=%h required 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_misaligned();
        run_instr(32'h0000_1163, 0, 0, 1'b0,
                  mk(5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 4'b0001, 32'h2, 1, 1, 32'h0, 32'h4, 1'b1));
    endtask

    initial begin
        test_reset();
        test_addi();
        test_add_wait();
        test_bne_taken();
        test_stall();
        test_back_to_back();
        test_wrap();
        test_illegal();
        test_reset_midfetch();
        test_misaligned();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
